// File: rtl/reset_sequencer_if.sv
// Signal bundle between the reset sequencer and the board/SoC side.
// The slave modport is the sequencer; the master modport is whoever drives
// the PLL lock, button and software requests and consumes the resets.
interface reset_sequencer_if #(
    parameter int NUM_DOMAINS = 3
);
    logic                   pll_locked;
    logic                   button;
    logic                   sw_reset_req;
    logic                   cause_clr;
    logic [NUM_DOMAINS-1:0] rst_n_out;
    logic                   ready;
    logic [3:0]             reset_cause;

    modport master (
        output pll_locked,
        output button,
        output sw_reset_req,
        output cause_clr,
        input  rst_n_out,
        input  ready,
        input  reset_cause
    );

    modport slave (
        input  pll_locked,
        input  button,
        input  sw_reset_req,
        input  cause_clr,
        output rst_n_out,
        output ready,
        output reset_cause
    );
endinterface

// File: rtl/reset_sequencer.sv
// Reset sequencer: holds all downstream reset domains until the PLL lock has
// been stable long enough, then releases them one by one with a fixed gap.
// Lock loss, a debounced button press or a software request puts everything
// back into reset, and a sticky cause register remembers why.
module reset_sequencer #(
    parameter int NUM_DOMAINS        = 3,
    parameter int MIN_ASSERT_CYCLES  = 16,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGGER_CYCLES     = 8,
    parameter int DEBOUNCE_CYCLES    = 1_200_000,
    parameter int SYNC_STAGES        = 2
) (
    input logic              clk,
    input logic              rst,
    reset_sequencer_if.slave bus
);
    localparam int ASSERT_W   = $clog2(MIN_ASSERT_CYCLES) + 1;
    localparam int LOCK_W     = $clog2(LOCK_STABLE_CYCLES) + 1;
    localparam int STAGGER_W  = $clog2(STAGGER_CYCLES) + 1;
    localparam int DEBOUNCE_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int INDEX_W    = $clog2(NUM_DOMAINS) + 1;

    localparam logic [ASSERT_W-1:0]   ASSERT_LAST   = ASSERT_W'(MIN_ASSERT_CYCLES - 1);
    localparam logic [LOCK_W-1:0]     LOCK_LIMIT    = LOCK_W'(LOCK_STABLE_CYCLES);
    localparam logic [STAGGER_W-1:0]  STAGGER_LAST  = STAGGER_W'(STAGGER_CYCLES - 1);
    localparam logic [DEBOUNCE_W-1:0] DEBOUNCE_LAST = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [INDEX_W-1:0]    INDEX_LAST    = INDEX_W'(NUM_DOMAINS - 1);

    typedef enum logic [1:0] {
        S_ASSERT,
        S_WAIT_LOCK,
        S_RELEASE,
        S_RUN
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] lock_sync;
    logic [SYNC_STAGES-1:0] btn_sync;
    logic                   locked_s;
    logic                   btn_s;

    logic                   btn_level;
    logic [DEBOUNCE_W-1:0]  deb_cnt;
    logic                   deb_done;
    logic                   press;

    logic [LOCK_W-1:0]      lock_cnt;
    logic [LOCK_W-1:0]      lock_cnt_next;
    logic                   lock_stable;

    logic                   lock_loss;
    logic                   any_trig;

    logic [ASSERT_W-1:0]    assert_cnt;
    logic [STAGGER_W-1:0]   stagger_cnt;
    logic [INDEX_W-1:0]     index;
    logic [NUM_DOMAINS-1:0] rst_n_reg;
    logic                   ready_reg;
    logic [3:0]             cause_reg;

    assign locked_s = lock_sync[SYNC_STAGES-1];
    assign btn_s    = btn_sync[SYNC_STAGES-1];

    // Bring the asynchronous lock and button inputs into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_sync <= '0;
            btn_sync  <= '0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], bus.pll_locked};
            btn_sync  <= {btn_sync[SYNC_STAGES-2:0], bus.button};
        end
    end

    // A new button level is accepted once it has disagreed with the current
    // one for the full debounce window; a press is the accepted 0->1 edge.
    assign deb_done = (btn_s != btn_level) && (deb_cnt >= DEBOUNCE_LAST);
    assign press    = deb_done && btn_s;

    // Debounce counter: restarts whenever the synchronised button agrees with the accepted level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_level <= 1'b0;
            deb_cnt   <= '0;
        end else if (btn_s == btn_level) begin
            deb_cnt <= '0;
        end else if (deb_done) begin
            btn_level <= btn_s;
            deb_cnt   <= '0;
        end else begin
            deb_cnt <= deb_cnt + DEBOUNCE_W'(1);
        end
    end

    // Run length of consecutive lock cycles, saturating at the stability limit.
    // It keeps counting during ASSERT so a lock that was already stable lets
    // WAIT_LOCK move on straight away.
    always_comb begin
        lock_cnt_next = '0;
        if (locked_s) begin
            if (lock_cnt >= LOCK_LIMIT) begin
                lock_cnt_next = LOCK_LIMIT;
            end else begin
                lock_cnt_next = lock_cnt + LOCK_W'(1);
            end
        end
    end

    assign lock_stable = (lock_cnt_next >= LOCK_LIMIT);

    // Holds the lock run-length counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_cnt <= '0;
        end else begin
            lock_cnt <= lock_cnt_next;
        end
    end

    // Lock loss only counts once domains may already be out of reset.
    assign lock_loss = !locked_s && ((state == S_RELEASE) || (state == S_RUN));
    assign any_trig  = press || bus.sw_reset_req || lock_loss;

    // Sticky cause record: clear first, then every trigger of this cycle sets its bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cause_reg <= 4'b0001;
        end else begin
            cause_reg <= (bus.cause_clr ? 4'b0000 : cause_reg)
                       | {bus.sw_reset_req, press, lock_loss, 1'b0};
        end
    end

    // Sequencing FSM with registered reset outputs; any trigger re-enters
    // ASSERT (or restarts it) and drops every domain on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_ASSERT;
            assert_cnt  <= '0;
            stagger_cnt <= '0;
            index       <= '0;
            rst_n_reg   <= '0;
            ready_reg   <= 1'b0;
        end else if (any_trig) begin
            state       <= S_ASSERT;
            assert_cnt  <= '0;
            stagger_cnt <= '0;
            index       <= '0;
            rst_n_reg   <= '0;
            ready_reg   <= 1'b0;
        end else begin
            case (state)
                S_ASSERT: begin
                    if (assert_cnt >= ASSERT_LAST) begin
                        state      <= S_WAIT_LOCK;
                        assert_cnt <= '0;
                    end else begin
                        assert_cnt <= assert_cnt + ASSERT_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_stable) begin
                        state       <= S_RELEASE;
                        stagger_cnt <= '0;
                        index       <= '0;
                    end
                end
                S_RELEASE: begin
                    if (stagger_cnt >= STAGGER_LAST) begin
                        stagger_cnt <= '0;
                        for (int i = 0; i < NUM_DOMAINS; i++) begin
                            if (INDEX_W'(i) == index) begin
                                rst_n_reg[i] <= 1'b1;
                            end
                        end
                        if (index >= INDEX_LAST) begin
                            state     <= S_RUN;
                            ready_reg <= 1'b1;
                        end else begin
                            index <= index + INDEX_W'(1);
                        end
                    end else begin
                        stagger_cnt <= stagger_cnt + STAGGER_W'(1);
                    end
                end
                S_RUN: begin
                    rst_n_reg <= '1;
                    ready_reg <= 1'b1;
                end
                default: begin
                    state     <= S_ASSERT;
                    rst_n_reg <= '0;
                    ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rst_n_out   = rst_n_reg;
    assign bus.ready       = ready_reg;
    assign bus.reset_cause = cause_reg;
endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised clock/reset management block between the board clocking (differential buffer + clock wizard) and the SoC instances. It holds every downstream reset domain in reset until the PLL reports a stable lock. It then releases the domains one at a time in a fixed staggered order. It re-enters reset on PLL lock loss, a debounced reset button press, or a software reset request, and keeps a sticky record of the reset cause.

## Interface
- NUM_DOMAINS, 3, number of independent reset outputs (≥1)
- MIN_ASSERT_CYCLES, 16, minimum cycles all domains stay in reset per entry (≥1)
- LOCK_STABLE_CYCLES, 1024, consecutive synchronised-lock cycles required before release (≥1)
- STAGGER_CYCLES, 8, cycles between successive domain releases (≥1)
- DEBOUNCE_CYCLES, 1_200_000, cycles the button must stay stable to be accepted (≥1)
- SYNC_STAGES, 2, flip-flop stages on each asynchronous input (≥2)
- clk  in  1  free-running reference clock (not the PLL output)
- rst  in  1  asynchronous, active-high reset (one clock; reset is asynchronous and active-high)
- pll_locked  in  1  asynchronous PLL lock indicator
- button  in  1  asynchronous raw reset button, active high
- sw_reset_req  in  1  synchronous single-cycle software reset pulse
- cause_clr  in  1  synchronous pulse; clears reset_cause
- rst_n_out  out  NUM_DOMAINS  per-domain active-low resets, bit 0 released first
- ready  out  1  high when all domains are released (state RUN)
- reset_cause  out  4  sticky: bit0 power-on/rst, bit1 lock loss, bit2 button, bit3 software

## Operation
- All outputs are registered. On rst: rst_n_out=0, ready=0, reset_cause=4'b0001, state=ASSERT, all counters 0, debounced button level 0.
- pll_locked and button each pass through a SYNC_STAGES synchroniser, giving locked_s and btn_s.
- Debounce: the accepted level changes only after btn_s differs from it for DEBOUNCE_CYCLES consecutive cycles. Any return to the accepted level restarts the count. A press is an accepted-level 0→1 transition, lasting one cycle.
- Triggers: press → bit2; sw_reset_req → bit3; locked_s=0 while in RELEASE or RUN → bit1. Simultaneous triggers set every corresponding bit.
- States:
  - ASSERT: all rst_n_out=0, ready=0. Counts MIN_ASSERT_CYCLES cycles, then goes to WAIT_LOCK. A trigger here records its cause and restarts the count.
  - WAIT_LOCK: counts consecutive locked_s=1 cycles. locked_s=0 zeroes the count and is not a trigger. Reaching LOCK_STABLE_CYCLES goes to RELEASE. A press or sw_reset_req goes to ASSERT.
  - RELEASE: index starts at 0. Every STAGGER_CYCLES cycles, rst_n_out[index] is set to 1 and index increments. On the edge that releases bit NUM_DOMAINS-1, go to RUN and set ready=1. Any trigger goes to ASSERT.
  - RUN: holds all rst_n_out=1. Any trigger goes to ASSERT.
- Entry into ASSERT drives all rst_n_out=0 and ready=0 on that same edge. Already-released domains are re-asserted together.
- reset_cause bits are set by triggers and never cleared by them. cause_clr zeroes all bits; a trigger in the same cycle wins for its own bit. bit0 is set only by rst.

## Timing
- Asynchronous input to internal use: SYNC_STAGES cycles. Button press to trigger: SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- Trigger to rst_n_out low: 1 cycle (the registered edge after the trigger cycle).
- Domain k rises STAGGER_CYCLES·(k+1) cycles after RELEASE entry. ready rises on the same edge as rst_n_out[NUM_DOMAINS-1].
- Best-case release of domain 0 after rst deassert: MIN_ASSERT_CYCLES + max(0, SYNC_STAGES + LOCK_STABLE_CYCLES − MIN_ASSERT_CYCLES) + STAGGER_CYCLES, ±1 cycle of synchroniser alignment.
- rst asserted mid-RELEASE or mid-RUN: outputs return to reset values asynchronously, with no cycle delay.
- Counter widths are sized with $clog2 of each limit + 1. Counters saturate and never wrap.

## Test plan
Bench uses NUM_DOMAINS=3, MIN_ASSERT=8, LOCK_STABLE=16, STAGGER=4, DEBOUNCE=10, SYNC_STAGES=2.
- Power-up, pll_locked held 1 → rst_n_out goes 001, 011, 111 at 4, 8, 12 cycles after RELEASE entry; ready rises with 111; reset_cause=0001.
- pll_locked toggles every 10 cycles in WAIT_LOCK → never leaves WAIT_LOCK, rst_n_out stays 000. Then held high → release after 16 stable cycles.
- In RUN, pll_locked drops → rst_n_out=000 and ready=0 within SYNC_STAGES+1 cycles; reset_cause bit1 set; full sequence repeats on relock.
- Button glitch of 5 cycles → no reset. Press of 20 cycles → ASSERT after 2+10 cycles, bit2 set. A single release does not retrigger.
- sw_reset_req in RELEASE after domain 0 is released → all 000 next cycle, bit3 set. cause_clr in RUN → reset_cause=0000.
- rst asserted mid-RELEASE → outputs 000, ready=0, reset_cause=0001 immediately.
